// File: rtl/vx_issue_scoreboard_if.sv
// rtl/vx_issue_scoreboard_if.sv - issue, dispatch and writeback signal bundle for vx_issue_scoreboard
//
// Purpose: groups the ibuffer-side request, the dispatch-side registered output
// and the writeback commit port of one issue slot.
// Ports (signals):
//   in_valid/in_ready            ibuffer -> scoreboard handshake
//   in_wis/in_wb/in_rd/in_rs1..3 instruction register usage
//   in_data                      opaque payload
//   out_valid/out_ready          scoreboard -> dispatch handshake
//   out_wis/out_data             registered copies of in_wis/in_data
//   wb_valid/wb_wis/wb_rd/wb_eop writeback commit
// Modports: master = ibuffer/dispatch/writeback side, slave = scoreboard.
interface vx_issue_scoreboard_if #(
   parameter int SLOT_WARPS = 4,
   parameter int NR_BITS    = 6,
   parameter int DATAW      = 128
);
   localparam int WIS_W = (SLOT_WARPS > 1) ? $clog2(SLOT_WARPS) : 1;

   logic               in_valid;
   logic               in_ready;
   logic [WIS_W-1:0]   in_wis;
   logic               in_wb;
   logic [NR_BITS-1:0] in_rd;
   logic [NR_BITS-1:0] in_rs1;
   logic [NR_BITS-1:0] in_rs2;
   logic [NR_BITS-1:0] in_rs3;
   logic [DATAW-1:0]   in_data;

   logic               out_valid;
   logic               out_ready;
   logic [WIS_W-1:0]   out_wis;
   logic [DATAW-1:0]   out_data;

   logic               wb_valid;
   logic [WIS_W-1:0]   wb_wis;
   logic [NR_BITS-1:0] wb_rd;
   logic               wb_eop;

   modport master (
      output in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
      input  in_ready,
      input  out_valid, out_wis, out_data,
      output out_ready,
      output wb_valid, wb_wis, wb_rd, wb_eop
   );

   modport slave (
      input  in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
      output in_ready,
      output out_valid, out_wis, out_data,
      input  out_ready,
      input  wb_valid, wb_wis, wb_rd, wb_eop
   );
endinterface

// File: rtl/vx_issue_scoreboard.sv
// rtl/vx_issue_scoreboard.sv - per-issue-slot RAW/WAW register scoreboard with registered output stage
//
// Purpose: holds back an instruction while any of its source registers, or its
// destination when it writes back, has an outstanding write for the same warp.
// Accepted instructions pass through a one-entry output register.
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   sb         vx_issue_scoreboard_if.slave (in_*, out_*, wb_* groups)
//   stall_cnt  saturating count of hazard-stall cycles
//   timeout    sticky flag: STALL_TIMEOUT consecutive stall cycles seen
module vx_issue_scoreboard #(
   parameter int SLOT_WARPS    = 4,
   parameter int NR_BITS       = 6,
   parameter int DATAW         = 128,
   parameter int STALL_TIMEOUT = 65535
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_issue_scoreboard_if.slave     sb,
   output logic [31:0]              stall_cnt,
   output logic                     timeout
);
   localparam int          WIS_W    = (SLOT_WARPS > 1) ? $clog2(SLOT_WARPS) : 1;
   localparam int          NUM_REGS = 2 ** NR_BITS;
   localparam logic [31:0] TO_LIM   = 32'(STALL_TIMEOUT);

   logic [SLOT_WARPS-1:0][NUM_REGS-1:0] pending_q, pending_d;
   logic                                out_valid_q, out_valid_d;
   logic [WIS_W-1:0]                    out_wis_q, out_wis_d;
   logic [DATAW-1:0]                    out_data_q, out_data_d;
   logic [31:0]                         stall_cnt_q, stall_cnt_d;
   logic [31:0]                         consec_q, consec_d;
   logic                                timeout_q, timeout_d;

   logic [NUM_REGS-1:0] warp_pend;
   logic                hazard;
   logic                accept;
   logic                stall;

   // Only the registered pending bits are consulted: a writeback in this
   // cycle unblocks the instruction one cycle later.
   always_comb begin
      warp_pend = pending_q[sb.in_wis];
      hazard    = warp_pend[sb.in_rs1] | warp_pend[sb.in_rs2] | warp_pend[sb.in_rs3]
                | (sb.in_wb & warp_pend[sb.in_rd]);
   end

   assign sb.in_ready = !hazard && (!out_valid_q || sb.out_ready);
   assign accept      = sb.in_valid && sb.in_ready;
   // Back-pressure alone is not a stall; only a register hazard counts.
   assign stall       = sb.in_valid && hazard;

   always_comb begin
      pending_d   = pending_q;
      out_valid_d = out_valid_q;
      out_wis_d   = out_wis_q;
      out_data_d  = out_data_q;
      stall_cnt_d = stall_cnt_q;
      consec_d    = consec_q;
      timeout_d   = timeout_q;

      // Clear first so that a same-cycle set of the same bit wins.
      if (sb.wb_valid && sb.wb_eop) begin
         pending_d[sb.wb_wis][sb.wb_rd] = 1'b0;
      end
      // Register 0 is hardwired and never tracked.
      if (accept && sb.in_wb && (sb.in_rd != '0)) begin
         pending_d[sb.in_wis][sb.in_rd] = 1'b1;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         out_wis_d   = sb.in_wis;
         out_data_d  = sb.in_data;
      end else if (sb.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end

      if (accept) begin
         consec_d = '0;
      end else if (stall && (consec_q < TO_LIM)) begin
         consec_d = consec_q + 32'd1;
      end

      if (consec_d == TO_LIM) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_wis_q   <= '0;
         out_data_q  <= '0;
         stall_cnt_q <= '0;
         consec_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_wis_q   <= out_wis_d;
         out_data_q  <= out_data_d;
         stall_cnt_q <= stall_cnt_d;
         consec_q    <= consec_d;
         timeout_q   <= timeout_d;
      end
   end

   assign sb.out_valid = out_valid_q;
   assign sb.out_wis   = out_wis_q;
   assign sb.out_data  = out_data_q;
   assign stall_cnt    = stall_cnt_q;
   assign timeout      = timeout_q;
endmodule
